// File: rtl/calc_display_mux_pkg.sv
// Shared definitions for the calculator display stage: core status codes,
// capture FSM states and 7-segment patterns (active-high, bit order g..a).
package calc_disp_pkg;

    // Status codes reported by the calculator core; 2'b11 behaves as pronto.
    localparam logic [1:0] ST_ERRO    = 2'b00;
    localparam logic [1:0] ST_OCUPADO = 2'b01;
    localparam logic [1:0] ST_PRONTO  = 2'b10;

    typedef enum logic [1:0] {
        CAP_IDLE    = 2'd0,
        CAP_CAPTURE = 2'd1,
        CAP_COMMIT  = 2'd2
    } cap_state_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_R     = 7'h50;
    localparam logic [6:0] SEG_O     = 7'h5C;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // "Erro" spelled across digits 3..0, upper digits blank.
    function automatic logic [6:0] err_pattern(input logic [2:0] idx);
        logic [6:0] p;
        p = SEG_BLANK;
        case (idx)
            3'd0:    p = SEG_O;
            3'd1:    p = SEG_R;
            3'd2:    p = SEG_R;
            3'd3:    p = SEG_E;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/calc_display_mux_if.sv
// Serialised digit stream from the calculator core into the display stage.
// There is no valid/ready pair: the core presents one (status, data, pos)
// sample every clock; a sample carries a digit only when status is ocupado
// and pos is 0..7, and the display stage is always ready to take it.
interface calc_display_mux_if;
    logic [1:0] status;
    logic [3:0] data;
    logic [3:0] pos;

    modport master (output status, data, pos);
    modport slave  (input  status, data, pos);
endinterface

// File: rtl/calc_display_mux_seg7_decoder.sv
// Combinational BCD to 7-segment decoder (active-high, g..a). Values 10..15
// and a raised blank flag both produce a dark digit.
module seg7_decoder
    import calc_disp_pkg::*;
(
    input  logic [3:0] value_i,
    input  logic       blank_i,
    output logic [6:0] pat_o
);

    // Pattern lookup; blank wins over the value.
    always_comb begin
        pat_o = SEG_BLANK;
        if (!blank_i) begin
            case (value_i)
                4'd0:    pat_o = SEG_0;
                4'd1:    pat_o = SEG_1;
                4'd2:    pat_o = SEG_2;
                4'd3:    pat_o = SEG_3;
                4'd4:    pat_o = SEG_4;
                4'd5:    pat_o = SEG_5;
                4'd6:    pat_o = SEG_6;
                4'd7:    pat_o = SEG_7;
                4'd8:    pat_o = SEG_8;
                4'd9:    pat_o = SEG_9;
                default: pat_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/calc_display_mux.sv
// Display stage of the calculator: rebuilds 8-digit frames from the core's
// digit stream in a shadow buffer, commits complete frames atomically and
// scans the committed buffer onto a common-anode 7-segment display.
// Optional feature macro: CALC_DISP_LEADING_ZERO_BLANK_EN (blank leading zeros).
module calc_display_mux
    import calc_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int NUM_DIGITS  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    calc_display_mux_if.slave     stream,
    output logic [NUM_DIGITS-1:0] an,
    output logic [7:0]            seg,
    output logic                  frame_done,
    output logic                  err_latched,
    output cap_state_t            dbg_state
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    cap_state_t            state_q, state_d;
    logic [3:0]            exp_q, exp_d;
    logic                  err_q;
    logic [3:0]            shadow_q [NUM_DIGITS];
    logic [3:0]            disp_q   [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] blank_q;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  wr_en;
    logic [2:0]            wr_idx;
    logic                  commit;
    logic                  ocupado;

    logic [CNT_W-1:0]      cnt_q;
    logic [2:0]            idx_q;
    logic                  wrap;
    logic [NUM_DIGITS-1:0] an_q;
    logic [7:0]            seg_q;
    logic [6:0]            dec_pat;
    logic [6:0]            pat_sel;

    assign ocupado = (stream.status == ST_OCUPADO);

    // Capture FSM: accept in-order digits, tolerate repeat holds, restart on
    // pos 0, abort on anything else; a completed frame commits next cycle.
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        wr_en   = 1'b0;
        wr_idx  = stream.pos[2:0];
        commit  = 1'b0;
        case (state_q)
            CAP_IDLE: begin
                if (ocupado && stream.pos == 4'd0) begin
                    wr_en   = 1'b1;
                    exp_d   = 4'd1;
                    state_d = CAP_CAPTURE;
                end
            end
            CAP_CAPTURE: begin
                if (ocupado && stream.pos == exp_q) begin
                    wr_en = 1'b1;
                    exp_d = exp_q + 4'd1;
                    if (stream.pos == 4'd7) state_d = CAP_COMMIT;
                end else if (ocupado && stream.pos == exp_q - 4'd1) begin
                    wr_en = 1'b1;
                end else if (ocupado && stream.pos == 4'd0) begin
                    wr_en = 1'b1;
                    exp_d = 4'd1;
                end else begin
                    state_d = CAP_IDLE;
                end
            end
            CAP_COMMIT: begin
                commit  = 1'b1;
                state_d = CAP_IDLE;
            end
            default: state_d = CAP_IDLE;
        endcase
    end

`ifdef CALC_DISP_LEADING_ZERO_BLANK_EN
    logic lz_seen;
    // Blank every digit above the most significant non-zero one; digit 0 always shows.
    always_comb begin
        lz_mask = '0;
        lz_seen = 1'b0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (shadow_q[i] != 4'd0) lz_seen = 1'b1;
            lz_mask[i] = !lz_seen;
        end
    end
`else
    assign lz_mask = '0;
`endif

    // Capture state, shadow/display buffers and the sticky error flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= CAP_IDLE;
            exp_q   <= 4'd0;
            err_q   <= 1'b0;
            blank_q <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= 4'd0;
                disp_q[i]   <= 4'd0;
            end
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            if (wr_en) shadow_q[wr_idx] <= stream.data;
            if (commit) begin
                disp_q  <= shadow_q;
                blank_q <= lz_mask;
            end
            if (stream.status == ST_ERRO) err_q <= 1'b1;
        end
    end

    assign wrap = (cnt_q == CNT_W'(REFRESH_DIV - 1));

    // Refresh divider and scan index.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            idx_q <= 3'd0;
        end else if (wrap) begin
            cnt_q <= '0;
            idx_q <= idx_q + 3'd1;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    seg7_decoder u_dec (
        .value_i (disp_q[idx_q]),
        .blank_i (blank_q[idx_q]),
        .pat_o   (dec_pat)
    );

    assign pat_sel = err_q ? err_pattern(idx_q) : dec_pat;

    // Registered display drive, reloaded once per scan slot; dp stays off.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            an_q  <= '1;
            seg_q <= 8'hFF;
        end else if (wrap) begin
            an_q  <= ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q);
            seg_q <= {1'b1, ~pat_sel};
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign frame_done  = (state_q == CAP_COMMIT);
    assign err_latched = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_calc_display_mux.sv
// Bench for calc_display_mux with a fast refresh divider. Expected display
// contents come from a frame-level model: a 32-bit committed value (digit i
// in nibble i) and a sticky error flag.
module tb_calc_display_mux;
    import calc_disp_pkg::*;

    localparam int DIV = 4;

    logic       clk;
    logic       rst;
    logic [7:0] an;
    logic [7:0] seg;
    logic       frame_done;
    logic       err_latched;
    cap_state_t dbg_state;

    calc_display_mux_if bus ();

    calc_display_mux #(.REFRESH_DIV(DIV), .NUM_DIGITS(8)) dut (
        .clock       (clk),
        .reset       (rst),
        .stream      (bus),
        .an          (an),
        .seg         (seg),
        .frame_done  (frame_done),
        .err_latched (err_latched),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int fd_cnt = 0;

    logic [31:0] model_frame = 32'h0;
    bit          model_err = 1'b0;

    always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] enc(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'd0: p = 7'h3F;  4'd1: p = 7'h06;  4'd2: p = 7'h5B;
            4'd3: p = 7'h4F;  4'd4: p = 7'h66;  4'd5: p = 7'h6D;
            4'd6: p = 7'h7D;  4'd7: p = 7'h07;  4'd8: p = 7'h7F;
            4'd9: p = 7'h6F;
            default: p = 7'h00;
        endcase
        return {1'b1, ~p};
    endfunction

    function automatic logic [7:0] exp_seg(input int i);
        if (model_err) begin
            case (i)
                0: return 8'hA3;
                1: return 8'hAF;
                2: return 8'hAF;
                3: return 8'h86;
                default: return 8'hFF;
            endcase
        end
`ifdef CALC_DISP_LEADING_ZERO_BLANK_EN
        if (i > 0 && (model_frame >> (4 * i)) == 32'h0) return 8'hFF;
`endif
        return enc(model_frame[4*i +: 4]);
    endfunction

    // driver tasks
    task automatic drive(input logic [1:0] st, input logic [3:0] d, input logic [3:0] p);
        bus.status = st;
        bus.data   = d;
        bus.pos    = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(ST_PRONTO, 4'h0, 4'hF);
    endtask

    task automatic send_frame(input logic [31:0] frame_in, input bit holds, output logic [31:0] frame_out);
        logic [31:0] f;
        logic [3:0]  nd;
        f = frame_in;
        for (int p = 0; p < 8; p++) begin
            drive(ST_OCUPADO, f[4*p +: 4], 4'(p));
            if (holds && p < 7 && $urandom_range(0, 3) == 0) begin
                nd = 4'($urandom_range(0, 15));
                f[4*p +: 4] = nd;
                drive(ST_OCUPADO, nd, 4'(p));
            end
        end
        check("frame_done_pulse", {31'b0, frame_done}, 32'd1);
        idle(1);
        check("frame_done_drop", {31'b0, frame_done}, 32'd0);
        frame_out = f;
    endtask

    task automatic send_abort(input logic [31:0] f, input int k, input int kind);
        for (int p = 0; p < k; p++) drive(ST_OCUPADO, f[4*p +: 4], 4'(p));
        if (kind == 0) drive(ST_PRONTO, f[4*k +: 4], 4'(k));
        else           drive(ST_OCUPADO, 4'h3, 4'(k + 2));
        idle(2);
    endtask

    // scoreboard: observe a full scan and compare every digit with the model
    task automatic check_display(input string name);
        logic [7:0] got [8];
        bit         seen [8];
        logic [7:0] sel;
        for (int i = 0; i < 8; i++) begin
            seen[i] = 1'b0;
            got[i]  = 8'h00;
        end
        repeat (2 * DIV) @(posedge clk);
        for (int c = 0; c < 9 * DIV; c++) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                sel = ~(8'h01 << i);
                if (an === sel) begin
                    seen[i] = 1'b1;
                    got[i]  = seg;
                end
            end
        end
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_digit%0d", name, i), {23'b0, seen[i], got[i]}, {23'b0, 1'b1, exp_seg(i)});
        #1;
    endtask

    typedef struct {
        logic [31:0] frame;
        int          abort_at;
        int          exp_done;
        logic [31:0] exp_frame;
    } vec_t;

    vec_t        vecs [5];
    logic [31:0] got_frame;
    logic [31:0] rf;
    int          fd0;
    int          exp_done;
    bit          seen_change;

    initial begin
        vecs[0] = '{32'h12345678, -1, 1, 32'h12345678};
        vecs[1] = '{32'h00000042, -1, 1, 32'h00000042};
        vecs[2] = '{32'h00000333,  3, 0, 32'h00000042};
        vecs[3] = '{32'h99999999, -1, 1, 32'h99999999};
        vecs[4] = '{32'h00000000, -1, 1, 32'h00000000};

        rst = 1'b1;
        bus.status = ST_PRONTO;
        bus.data   = 4'h0;
        bus.pos    = 4'hF;
        @(negedge clk);
        @(negedge clk);
        check("rst_an", {24'b0, an}, 32'hFF);
        check("rst_seg", {24'b0, seg}, 32'hFF);
        check("rst_err", {31'b0, err_latched}, 32'd0);
        check("rst_done", {31'b0, frame_done}, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(CAP_IDLE));
        rst = 1'b0;

        // first scan slot after reset shows digit 0 of an all-zero buffer
        seen_change = 1'b0;
        for (int c = 0; c < 20 && !seen_change; c++) begin
            @(negedge clk);
            if (an !== 8'hFF) seen_change = 1'b1;
        end
        check("first_wrap_an", {24'b0, an}, 32'hFE);
        check("first_wrap_seg", {24'b0, seg}, 32'hC0);
        @(posedge clk);
        #1;

        // table-driven frames
        for (int v = 0; v < 5; v++) begin
            fd0 = fd_cnt;
            if (vecs[v].abort_at < 0) send_frame(vecs[v].frame, 1'b0, got_frame);
            else send_abort(vecs[v].frame, vecs[v].abort_at, 1);
            idle(1);
            check($sformatf("vec%0d_commits", v), 32'(fd_cnt - fd0), 32'(vecs[v].exp_done));
            model_frame = vecs[v].exp_frame;
            check_display($sformatf("vec%0d", v));
        end

        // restart on pos 0 in the middle of a frame
        fd0 = fd_cnt;
        drive(ST_OCUPADO, 4'h1, 4'd0);
        drive(ST_OCUPADO, 4'h2, 4'd1);
        drive(ST_OCUPADO, 4'h3, 4'd2);
        send_frame(32'h76543215, 1'b0, got_frame);
        check("restart_commits", 32'(fd_cnt - fd0), 32'd1);
        model_frame = got_frame;
        check_display("restart");

        // randomized frames with repeat holds and aborts
        for (int r = 0; r < 8; r++) begin
            rf  = $urandom;
            fd0 = fd_cnt;
            if ($urandom_range(0, 2) == 0) begin
                send_abort(rf, int'($urandom_range(1, 7)), int'($urandom_range(0, 1)));
                exp_done = 0;
            end else begin
                send_frame(rf, 1'b1, got_frame);
                model_frame = got_frame;
                exp_done = 1;
            end
            idle(1);
            check($sformatf("rand%0d_commits", r), 32'(fd_cnt - fd0), 32'(exp_done));
            check_display($sformatf("rand%0d", r));
        end

        // asynchronous reset in the middle of a frame
        for (int p = 0; p < 4; p++) drive(ST_OCUPADO, 4'h9, 4'(p));
        #2;
        rst = 1'b1;
        #1;
        check("midrst_an", {24'b0, an}, 32'hFF);
        check("midrst_seg", {24'b0, seg}, 32'hFF);
        check("midrst_done", {31'b0, frame_done}, 32'd0);
        check("midrst_state", 32'(dbg_state), 32'(CAP_IDLE));
        @(negedge clk);
        rst = 1'b0;
        model_frame = 32'h0;
        send_frame(32'h24681357, 1'b0, got_frame);
        model_frame = got_frame;
        check_display("after_rst");

        // error during capture latches and masks the display
        drive(ST_OCUPADO, 4'h1, 4'd0);
        drive(ST_OCUPADO, 4'h2, 4'd1);
        check("err_before", {31'b0, err_latched}, 32'd0);
        drive(ST_ERRO, 4'h0, 4'd2);
        check("err_set", {31'b0, err_latched}, 32'd1);
        idle(3);
        model_err = 1'b1;
        check_display("err");
        send_frame(32'h11111111, 1'b0, got_frame);
        model_frame = got_frame;
        check_display("err_after_commit");
        check("err_hold", {31'b0, err_latched}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
